// File: rtl/dqt_stream_parser.sv
// Streaming DQT segment parser: walks the tables after an FFDB marker and writes entries to the quant RAM.
// Optional 16-bit precision tables are enabled by the DQT_PREC16_EN macro.
module dqt_stream_parser #(
    parameter int NUM_TABLES = 4,
    parameter int QW         = 16,
    localparam int TW        = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  q_we,
    output logic [TW-1:0]         q_tbl,
    output logic [5:0]            q_addr,
    output logic [QW-1:0]         q_data,
    output logic                  tbl_done,
    output logic [NUM_TABLES-1:0] tbl_valid,
    output logic [NUM_TABLES-1:0] tbl_prec,
    input  logic                  clear,
    output logic                  busy,
    output logic                  seg_done,
    output logic                  err,
    output logic [2:0]            err_code
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, PQTQ, ENT_HI, ENT_LO, DRAIN, DONE
    } state_t;

    localparam logic [2:0] E_LEN   = 3'd1;
    localparam logic [2:0] E_DEST  = 3'd2;
    localparam logic [2:0] E_PREC  = 3'd3;
    localparam logic [2:0] E_TRUNC = 3'd4;

    state_t                  state_q, state_d;
    logic [15:0]             rem_q, rem_d;
    logic [5:0]              k_q, k_d;
    logic [7:0]              len_hi_q, len_hi_d;
    logic [TW-1:0]           tq_q, tq_d;
    logic                    pq_q, pq_d;
    logic                    q_we_q, q_we_d;
    logic [TW-1:0]           q_tbl_q, q_tbl_d;
    logic [5:0]              q_addr_q, q_addr_d;
    logic [QW-1:0]           q_data_q, q_data_d;
    logic                    tbl_done_q, tbl_done_d;
    logic [NUM_TABLES-1:0]   tbl_valid_q, tbl_valid_d;
    logic [NUM_TABLES-1:0]   tbl_prec_q, tbl_prec_d;
    logic                    seg_done_q, seg_done_d;
    logic                    err_q, err_d;
    logic [2:0]              err_code_q, err_code_d;
`ifdef DQT_PREC16_EN
    logic [7:0]              hi_q, hi_d;
`endif

    logic                    acc;
    logic [15:0]             lq;
    logic [15:0]             ent;
    logic                    bad_dest, bad_prec;
    logic                    set_bit, clr_bit;
    logic [TW-1:0]           bit_idx;

    assign acc = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        k_d         = k_q;
        len_hi_d    = len_hi_q;
        tq_d        = tq_q;
        pq_d        = pq_q;
        q_we_d      = 1'b0;
        q_tbl_d     = q_tbl_q;
        q_addr_d    = q_addr_q;
        q_data_d    = q_data_q;
        tbl_done_d  = 1'b0;
        seg_done_d  = 1'b0;
        err_d       = err_q;
        err_code_d  = err_code_q;
`ifdef DQT_PREC16_EN
        hi_d        = hi_q;
`endif
        s_ready     = 1'b0;
        lq          = {len_hi_q, s_data};
        ent         = {8'h00, s_data};
        bad_dest    = ({1'b0, s_data[3:0]} >= 5'(NUM_TABLES));
`ifdef DQT_PREC16_EN
        bad_prec    = (s_data[7:4] > 4'd1);
`else
        bad_prec    = (s_data[7:4] != 4'd0);
`endif
        set_bit     = 1'b0;
        clr_bit     = 1'b0;
        bit_idx     = tq_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LEN_HI;
                    err_d      = 1'b0;
                    err_code_d = '0;
                end
            end
            LEN_HI: begin
                s_ready = 1'b1;
                if (acc) begin
                    len_hi_d = s_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                s_ready = 1'b1;
                if (acc) begin
                    rem_d = lq - 16'd2;
                    if (lq < 16'd3) begin
                        err_d      = 1'b1;
                        err_code_d = E_LEN;
                        state_d    = DONE;
                    end else begin
                        state_d = PQTQ;
                    end
                end
            end
            PQTQ: begin
                s_ready = 1'b1;
                if (acc) begin
                    rem_d   = rem_q - 16'd1;
                    tq_d    = s_data[TW-1:0];
                    pq_d    = s_data[4];
                    k_d     = '0;
                    bit_idx = s_data[TW-1:0];
                    if (bad_dest || bad_prec) begin
                        err_d      = 1'b1;
                        err_code_d = bad_dest ? E_DEST : E_PREC;
                        state_d    = (rem_q > 16'd1) ? DRAIN : DONE;
                    end else if (rem_q <= 16'd1) begin
                        // table header with no entries behind it is a truncated table
                        err_d      = 1'b1;
                        err_code_d = E_TRUNC;
                        clr_bit    = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = s_data[4] ? ENT_HI : ENT_LO;
                    end
                end
            end
`ifdef DQT_PREC16_EN
            ENT_HI: begin
                s_ready = 1'b1;
                if (acc) begin
                    hi_d  = s_data;
                    rem_d = rem_q - 16'd1;
                    if (rem_q <= 16'd1) begin
                        err_d      = 1'b1;
                        err_code_d = E_TRUNC;
                        clr_bit    = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = ENT_LO;
                    end
                end
            end
`endif
            ENT_LO: begin
                s_ready = 1'b1;
                if (acc) begin
`ifdef DQT_PREC16_EN
                    ent = pq_q ? {hi_q, s_data} : {8'h00, s_data};
`endif
                    rem_d    = rem_q - 16'd1;
                    q_we_d   = 1'b1;
                    q_addr_d = k_q;
                    q_data_d = QW'(ent);
                    q_tbl_d  = tq_q;
                    k_d      = k_q + 6'd1;
                    if (k_q == 6'd63) begin
                        tbl_done_d = 1'b1;
                        set_bit    = 1'b1;
                        state_d    = (rem_q > 16'd1) ? PQTQ : DONE;
                    end else if (rem_q <= 16'd1) begin
                        err_d      = 1'b1;
                        err_code_d = E_TRUNC;
                        clr_bit    = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = pq_q ? ENT_HI : ENT_LO;
                    end
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (acc) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q <= 16'd1) state_d = DONE;
                end
            end
            DONE: begin
                seg_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // clear drops every slot, but a completion in the same cycle still lands
        tbl_valid_d = clear ? '0 : tbl_valid_q;
        tbl_prec_d  = clear ? '0 : tbl_prec_q;
        if (clr_bit) tbl_valid_d[bit_idx] = 1'b0;
        if (set_bit) begin
            tbl_valid_d[bit_idx] = 1'b1;
            tbl_prec_d[bit_idx]  = pq_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            k_q         <= '0;
            len_hi_q    <= '0;
            tq_q        <= '0;
            pq_q        <= 1'b0;
            q_we_q      <= 1'b0;
            q_tbl_q     <= '0;
            q_addr_q    <= '0;
            q_data_q    <= '0;
            tbl_done_q  <= 1'b0;
            tbl_valid_q <= '0;
            tbl_prec_q  <= '0;
            seg_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
`ifdef DQT_PREC16_EN
            hi_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            k_q         <= k_d;
            len_hi_q    <= len_hi_d;
            tq_q        <= tq_d;
            pq_q        <= pq_d;
            q_we_q      <= q_we_d;
            q_tbl_q     <= q_tbl_d;
            q_addr_q    <= q_addr_d;
            q_data_q    <= q_data_d;
            tbl_done_q  <= tbl_done_d;
            tbl_valid_q <= tbl_valid_d;
            tbl_prec_q  <= tbl_prec_d;
            seg_done_q  <= seg_done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
`ifdef DQT_PREC16_EN
            hi_q        <= hi_d;
`endif
        end
    end

    assign q_we      = q_we_q;
    assign q_tbl     = q_tbl_q;
    assign q_addr    = q_addr_q;
    assign q_data    = q_data_q;
    assign tbl_done  = tbl_done_q;
    assign tbl_valid = tbl_valid_q;
    assign tbl_prec  = tbl_prec_q;
    assign seg_done  = seg_done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != IDLE);

endmodule
